// File: rtl/zf_pkg.sv
// Shared ZF preprocessing definitions: operand widths, the arbiter state
// encoding and a small one-hot helper used by the multiplier arbiter.
package zf_pkg;

   localparam int ZF_MAT_W = 512;
   localparam int ZF_VEC_W = 256;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_WAIT    = 2'd2,
      ST_DELIVER = 2'd3
   } zf_arb_state_t;

   // Requester index to its one-hot bit in a 2-wide vector
   function automatic logic [1:0] zf_onehot2(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/zf_mul_arbiter_if.sv
// Bus bundle between the two ZF requesters, the shared multiplier and the
// arbiter. The slave modport is the arbiter's view, master the environment's.
interface zf_mul_arbiter_if;
   import zf_pkg::*;

   logic [1:0]                   req;
   logic [1:0][ZF_MAT_W-1:0]     req_a;
   logic [1:0][ZF_VEC_W-1:0]     req_b;
   logic [1:0]                   req_ack;
   logic                         mul_start;
   logic [ZF_MAT_W-1:0]          mul_a;
   logic [ZF_VEC_W-1:0]          mul_b;
   logic                         mul_done;
   logic [ZF_VEC_W-1:0]          mul_res;
   logic [1:0]                   rsp_valid;
   logic [ZF_VEC_W-1:0]          rsp_data;
   logic                         rsp_err;
   logic [1:0]                   rsp_accept;
   logic                         busy;

   modport slave (
      input  req, req_a, req_b, mul_done, mul_res, rsp_accept,
      output req_ack, mul_start, mul_a, mul_b, rsp_valid, rsp_data, rsp_err, busy
   );

   modport master (
      output req, req_a, req_b, mul_done, mul_res, rsp_accept,
      input  req_ack, mul_start, mul_a, mul_b, rsp_valid, rsp_data, rsp_err, busy
   );

endinterface

// File: rtl/zf_rr_arbiter2.sv
// Combinational 2-way round-robin pick. A lone request always wins; when both
// requesters are active the side named by i_rr_ptr wins.
module zf_rr_arbiter2 (
   input  logic [1:0] i_req,
   input  logic       i_rr_ptr,
   output logic       o_grant_valid,
   output logic       o_grant_idx
);

   // select the winner from the request pattern and the priority pointer
   always_comb begin
      o_grant_valid = |i_req;
      case (i_req)
         2'b01:   o_grant_idx = 1'b0;
         2'b10:   o_grant_idx = 1'b1;
         2'b11:   o_grant_idx = i_rr_ptr;
         default: o_grant_idx = 1'b0;
      endcase
   end

endmodule

// File: rtl/zf_mul_arbiter.sv
// Shares one mul_4x4_4x2 multiplier between two ZF requesters: round-robin
// grant, registered operands with a one-cycle start, capture of the product
// on done and return over a valid/accept handshake.
// Optional feature macro: ZF_ARB_TIMEOUT_EN (WAIT timeout with rsp_err).
module zf_mul_arbiter
   import zf_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic            clk,
   input  logic            reset,
   zf_mul_arbiter_if.slave bus
);

   zf_arb_state_t         r_state;
   zf_arb_state_t         w_state_nxt;
   logic                  r_owner;
   logic                  r_rr_ptr;
   logic [ZF_MAT_W-1:0]   r_mul_a;
   logic [ZF_VEC_W-1:0]   r_mul_b;
   logic [ZF_VEC_W-1:0]   r_rsp_data;
   logic                  w_grant_valid;
   logic                  w_grant_idx;
   logic                  w_do_grant;
   logic                  w_done_wait;
   logic                  w_timeout;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("zf_mul_arbiter: TIMEOUT_CYCLES must be at least 1");
   end

   zf_rr_arbiter2 u_rr (
      .i_req         (bus.req),
      .i_rr_ptr      (r_rr_ptr),
      .o_grant_valid (w_grant_valid),
      .o_grant_idx   (w_grant_idx)
   );

   // Requests are only looked at in IDLE; done is only honoured in WAIT so a
   // done level left over from the previous job cannot complete the new one.
   assign w_do_grant  = (r_state == ST_IDLE) && w_grant_valid;
   assign w_done_wait = (r_state == ST_WAIT) && bus.mul_done;

`ifdef ZF_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] r_wait_cnt;
   logic             r_rsp_err;

   // count WAIT cycles; held at zero elsewhere so every WAIT entry restarts it
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_wait_cnt <= '0;
      else if (r_state != ST_WAIT)
         r_wait_cnt <= '0;
      else if (!w_timeout)
         r_wait_cnt <= r_wait_cnt + 1'b1;
   end

   assign w_timeout = (r_state == ST_WAIT) && (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES));

   // error flag: a real done always wins over a coincident timeout
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_rsp_err <= 1'b0;
      else if (w_done_wait)
         r_rsp_err <= 1'b0;
      else if (w_timeout)
         r_rsp_err <= 1'b1;
   end

   assign bus.rsp_err = r_rsp_err;
`else
   assign w_timeout   = 1'b0;
   assign bus.rsp_err = 1'b0;
`endif

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   // next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:    if (w_grant_valid) w_state_nxt = ST_ISSUE;
         ST_ISSUE:   w_state_nxt = ST_WAIT;
         ST_WAIT:    if (w_done_wait || w_timeout) w_state_nxt = ST_DELIVER;
         ST_DELIVER: if (bus.rsp_accept[r_owner]) w_state_nxt = ST_IDLE;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   // on grant: remember the owner, hand priority to the other side, latch operands
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_owner  <= 1'b0;
         r_rr_ptr <= 1'b0;
         r_mul_a  <= '0;
         r_mul_b  <= '0;
      end else if (w_do_grant) begin
         r_owner  <= w_grant_idx;
         r_rr_ptr <= ~w_grant_idx;
         r_mul_a  <= bus.req_a[w_grant_idx];
         r_mul_b  <= bus.req_b[w_grant_idx];
      end
   end

   // capture the product on the first done in WAIT; a timeout returns zeros
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_rsp_data <= '0;
      else if (w_done_wait)
         r_rsp_data <= bus.mul_res;
      else if (w_timeout)
         r_rsp_data <= '0;
   end

   // outputs decoded from registered state only
   always_comb begin
      bus.mul_start = (r_state == ST_ISSUE);
      bus.req_ack   = (r_state == ST_ISSUE)   ? zf_onehot2(r_owner) : 2'b00;
      bus.rsp_valid = (r_state == ST_DELIVER) ? zf_onehot2(r_owner) : 2'b00;
      bus.busy      = (r_state != ST_IDLE);
   end

   assign bus.mul_a    = r_mul_a;
   assign bus.mul_b    = r_mul_b;
   assign bus.rsp_data = r_rsp_data;

endmodule

// File: tb/tb_zf_mul_arbiter.sv
// Directed bench for zf_mul_arbiter: a vector table of single jobs plus
// hand-written sequences for stale done, backpressure, alternation, reset
// during WAIT and (with ZF_ARB_TIMEOUT_EN) the timeout path.
module tb_zf_mul_arbiter;
   import zf_pkg::*;

   logic clk;
   logic reset;
   int   n_checks = 0;
   int   n_errors = 0;

   zf_mul_arbiter_if bus();

   zf_mul_arbiter #(.TIMEOUT_CYCLES(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]          req;
      logic [ZF_MAT_W-1:0] a0;
      logic [ZF_MAT_W-1:0] a1;
      logic [ZF_VEC_W-1:0] b0;
      logic [ZF_VEC_W-1:0] b1;
      int                  lat;
      int                  acc;
      logic [1:0]          exp_ack;
      logic [ZF_VEC_W-1:0] exp_data;
   } vec_t;

   vec_t vt[7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [ZF_MAT_W-1:0] mk_diag(input int d);
      logic [ZF_MAT_W-1:0] m = '0;
      for (int r = 0; r < 4; r++) m[(r*4+r)*32 +: 32] = 32'(d);
      return m;
   endfunction

   function automatic logic [ZF_MAT_W-1:0] mk_perm01();
      logic [ZF_MAT_W-1:0] m = '0;
      m[(0*4+1)*32 +: 32] = 32'd1;
      m[(1*4+0)*32 +: 32] = 32'd1;
      m[(2*4+2)*32 +: 32] = 32'd1;
      m[(3*4+3)*32 +: 32] = 32'd1;
      return m;
   endfunction

   function automatic logic [ZF_VEC_W-1:0] mk_vec(input int base, input int scale);
      logic [ZF_VEC_W-1:0] v = '0;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = 32'(scale * (base + i));
      return v;
   endfunction

   function automatic logic [ZF_VEC_W-1:0] swap01(input logic [ZF_VEC_W-1:0] v);
      return {v[255:128], v[63:0], v[127:64]};
   endfunction

   // reference 4x4 * 4x2 product, 32-bit elements, wrap-around arithmetic
   function automatic logic [ZF_VEC_W-1:0] matmul(input logic [ZF_MAT_W-1:0] a,
                                                  input logic [ZF_VEC_W-1:0] b);
      logic [ZF_VEC_W-1:0] c = '0;
      logic [31:0]         acc;
      for (int r = 0; r < 4; r++) begin
         for (int col = 0; col < 2; col++) begin
            acc = '0;
            for (int k = 0; k < 4; k++)
               acc = acc + a[(r*4+k)*32 +: 32] * b[(k*2+col)*32 +: 32];
            c[(r*2+col)*32 +: 32] = acc;
         end
      end
      return c;
   endfunction

   task automatic run_vec(input vec_t v, input int idx);
      bus.req_a[0] = v.a0;
      bus.req_a[1] = v.a1;
      bus.req_b[0] = v.b0;
      bus.req_b[1] = v.b1;
      bus.req      = v.req;
      tick();
      check($sformatf("v%0d issue", idx), {bus.mul_start, bus.busy, bus.req_ack}, {2'b11, v.exp_ack});
      check($sformatf("v%0d mul_a", idx), bus.mul_a, (v.exp_ack == 2'b10) ? v.a1 : v.a0);
      check($sformatf("v%0d mul_b", idx), bus.mul_b, (v.exp_ack == 2'b10) ? v.b1 : v.b0);
      bus.req = 2'b00;
      repeat (v.lat) tick();
      check($sformatf("v%0d wait no valid", idx), bus.rsp_valid, 2'b00);
      bus.mul_done = 1'b1;
      bus.mul_res  = matmul(bus.mul_a, bus.mul_b);
      tick();
      bus.mul_done = 1'b0;
      bus.mul_res  = '0;
      check($sformatf("v%0d valid", idx), {bus.rsp_valid, bus.rsp_err, bus.mul_start}, {v.exp_ack, 2'b00});
      check($sformatf("v%0d data", idx), bus.rsp_data, v.exp_data);
      repeat (v.acc) tick();
      check($sformatf("v%0d valid held", idx), bus.rsp_valid, v.exp_ack);
      bus.rsp_accept = v.exp_ack;
      tick();
      bus.rsp_accept = 2'b00;
      check($sformatf("v%0d idle", idx), {bus.busy, bus.rsp_valid}, 3'b000);
   endtask

   initial begin
      vt[0] = '{2'b01, mk_diag(1), '0, mk_vec(1, 1), '0, 5, 2, 2'b01, mk_vec(1, 1)};
      vt[1] = '{2'b10, '0, mk_diag(3), '0, mk_vec(10, 1), 3, 0, 2'b10, mk_vec(10, 3)};
      vt[2] = '{2'b11, mk_perm01(), mk_diag(2), mk_vec(20, 1), mk_vec(30, 1), 2, 1, 2'b01,
                swap01(mk_vec(20, 1))};
      vt[3] = '{2'b11, mk_perm01(), mk_diag(2), mk_vec(20, 1), mk_vec(30, 1), 2, 1, 2'b10,
                mk_vec(30, 2)};
      vt[4] = '{2'b11, mk_diag(5), mk_diag(1), mk_vec(7, 1), mk_vec(8, 1), 1, 0, 2'b01,
                mk_vec(7, 5)};
      vt[5] = '{2'b01, mk_diag(2), '0, mk_vec(100, 1), '0, 2, 0, 2'b01, mk_vec(100, 2)};
      vt[6] = '{2'b10, '0, mk_diag(7), '0, mk_vec(3, 1), 4, 3, 2'b10, mk_vec(3, 7)};

      reset          = 1'b1;
      bus.req        = 2'b00;
      bus.req_a      = '0;
      bus.req_b      = '0;
      bus.mul_done   = 1'b0;
      bus.mul_res    = '0;
      bus.rsp_accept = 2'b00;
      repeat (3) tick();
      check("reset ctrl", {bus.req_ack, bus.mul_start, bus.rsp_valid, bus.rsp_err, bus.busy}, 7'd0);
      check("reset data", {bus.mul_a, bus.mul_b, bus.rsp_data}, '0);
      reset = 1'b0;
      tick();
      check("idle after reset", bus.busy, 1'b0);

      for (int i = 0; i < 7; i++) run_vec(vt[i], i);

      // stale done: done stays high from the previous job through ISSUE
      bus.req_a[0] = mk_diag(1);
      bus.req_b[0] = mk_vec(200, 1);
      bus.req      = 2'b01;
      tick();
      bus.req = 2'b00;
      tick();
      bus.mul_done = 1'b1;
      bus.mul_res  = matmul(bus.mul_a, bus.mul_b);
      tick();
      check("stale prev data", bus.rsp_data, mk_vec(200, 1));
      bus.mul_res    = mk_vec(300, 1);
      bus.rsp_accept = 2'b01;
      tick();
      bus.rsp_accept = 2'b00;
      bus.req_a[1]   = mk_diag(4);
      bus.req_b[1]   = mk_vec(40, 1);
      bus.req        = 2'b10;
      tick();
      check("stale issue ack", {bus.mul_start, bus.req_ack}, 3'b110);
      bus.req = 2'b00;
      tick();
      check("stale ignored in issue", {bus.busy, bus.rsp_valid}, 3'b100);
      bus.mul_res = matmul(bus.mul_a, bus.mul_b);
      tick();
      bus.mul_done = 1'b0;
      check("stale first wait capture", {bus.rsp_valid, bus.rsp_data}, {2'b10, mk_vec(40, 4)});
      bus.rsp_accept = 2'b10;
      tick();
      bus.rsp_accept = 2'b00;

      // backpressure with requester 1 pending and a spurious accept
      bus.req_a[0] = mk_diag(1);
      bus.req_b[0] = mk_vec(60, 1);
      bus.req_a[1] = mk_diag(2);
      bus.req_b[1] = mk_vec(70, 1);
      bus.req      = 2'b01;
      tick();
      check("bp ack0", bus.req_ack, 2'b01);
      bus.req = 2'b10;
      tick();
      bus.mul_done = 1'b1;
      bus.mul_res  = matmul(bus.mul_a, bus.mul_b);
      tick();
      bus.mul_done = 1'b0;
      for (int i = 0; i < 20; i++) begin
         check($sformatf("bp hold %0d", i),
               {bus.rsp_valid, bus.mul_start, bus.req_ack, bus.busy, bus.rsp_data},
               {2'b01, 1'b0, 2'b00, 1'b1, mk_vec(60, 1)});
         bus.rsp_accept = (i == 5) ? 2'b10 : 2'b00;
         tick();
      end
      bus.rsp_accept = 2'b00;
      check("bp after spurious", bus.rsp_valid, 2'b01);
      bus.rsp_accept = 2'b01;
      tick();
      bus.rsp_accept = 2'b00;
      check("bp idle m+1", {bus.busy, bus.mul_start}, 2'b00);
      tick();
      check("bp start m+2", {bus.mul_start, bus.req_ack}, 3'b110);
      check("bp mul_b", bus.mul_b, mk_vec(70, 1));
      bus.req = 2'b00;
      tick();
      bus.mul_done = 1'b1;
      bus.mul_res  = matmul(bus.mul_a, bus.mul_b);
      tick();
      bus.mul_done = 1'b0;
      check("bp job1 data", {bus.rsp_valid, bus.rsp_data}, {2'b10, mk_vec(70, 2)});
      bus.rsp_accept = 2'b10;
      tick();
      bus.rsp_accept = 2'b00;

      // continuous req=11 with immediate accepts: strict alternation
      bus.req_a[0] = mk_diag(1);
      bus.req_b[0] = mk_vec(1, 1);
      bus.req_a[1] = mk_diag(3);
      bus.req_b[1] = mk_vec(50, 1);
      bus.req      = 2'b11;
      for (int j = 0; j < 8; j++) begin
         logic [1:0] e;
         e = (j % 2 == 1) ? 2'b10 : 2'b01;
         tick();
         check($sformatf("alt %0d ack", j), {bus.mul_start, bus.req_ack}, {1'b1, e});
         tick();
         bus.mul_done = 1'b1;
         bus.mul_res  = matmul(bus.mul_a, bus.mul_b);
         tick();
         bus.mul_done = 1'b0;
         check($sformatf("alt %0d rsp", j), {bus.rsp_valid, bus.rsp_data},
               {e, (e == 2'b10) ? mk_vec(50, 3) : mk_vec(1, 1)});
         bus.rsp_accept = e;
         tick();
         bus.rsp_accept = 2'b00;
      end
      bus.req = 2'b00;

      // reset in the fifth WAIT cycle after granting requester 0
      bus.req_b[0] = mk_vec(5, 1);
      bus.req      = 2'b01;
      tick();
      bus.req = 2'b00;
      tick();
      repeat (4) tick();
      check("pre-reset busy", bus.busy, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      check("async reset ctrl", {bus.req_ack, bus.mul_start, bus.rsp_valid, bus.rsp_err, bus.busy}, 7'd0);
      check("async reset data", {bus.mul_a, bus.mul_b, bus.rsp_data}, '0);
      check("async reset rr_ptr", dut.r_rr_ptr, 1'b0);
      tick();
      reset   = 1'b0;
      bus.req = 2'b11;
      tick();
      check("post-reset grant 0", {bus.mul_start, bus.req_ack}, 3'b101);
      bus.req = 2'b00;
      tick();
      bus.mul_done = 1'b1;
      bus.mul_res  = matmul(bus.mul_a, bus.mul_b);
      tick();
      bus.mul_done = 1'b0;
      check("post-reset data", {bus.rsp_valid, bus.rsp_data}, {2'b01, mk_vec(5, 1)});
      bus.rsp_accept = 2'b01;
      tick();
      bus.rsp_accept = 2'b00;

`ifdef ZF_ARB_TIMEOUT_EN
      // no done at all: abort after 8 counted WAIT cycles
      bus.req_b[0] = mk_vec(9, 1);
      bus.req      = 2'b01;
      tick();
      bus.req = 2'b00;
      tick();
      repeat (8) tick();
      check("to before", bus.rsp_valid, 2'b00);
      tick();
      check("to abort", {bus.rsp_valid, bus.rsp_err, bus.rsp_data}, {2'b01, 1'b1, 256'd0});
      bus.rsp_accept = 2'b01;
      tick();
      bus.rsp_accept = 2'b00;
      // done on the timeout cycle wins
      bus.req = 2'b01;
      tick();
      bus.req = 2'b00;
      tick();
      repeat (8) tick();
      check("to tie before", bus.rsp_valid, 2'b00);
      bus.mul_done = 1'b1;
      bus.mul_res  = matmul(bus.mul_a, bus.mul_b);
      tick();
      bus.mul_done = 1'b0;
      check("to tie done wins", {bus.rsp_valid, bus.rsp_err, bus.rsp_data}, {2'b01, 1'b0, mk_vec(9, 1)});
      bus.rsp_accept = 2'b01;
      tick();
      bus.rsp_accept = 2'b00;
`else
      // without the timeout, WAIT lasts as long as done stays low
      bus.req_b[0] = mk_vec(9, 1);
      bus.req      = 2'b01;
      tick();
      bus.req = 2'b00;
      tick();
      repeat (12) tick();
      check("long wait", {bus.busy, bus.rsp_valid, bus.rsp_err}, 4'b1000);
      bus.mul_done = 1'b1;
      bus.mul_res  = matmul(bus.mul_a, bus.mul_b);
      tick();
      bus.mul_done = 1'b0;
      check("long wait done", {bus.rsp_valid, bus.rsp_err, bus.rsp_data}, {2'b01, 1'b0, mk_vec(9, 1)});
      bus.rsp_accept = 2'b01;
      tick();
      bus.rsp_accept = 2'b00;
`endif

      check("final idle", bus.busy, 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/zf_mul_arbiter.md
# zf_mul_arbiter

Shares one `mul_4x4_4x2` matrix multiplier between two requesters, typically the y-path and n-path of the ZF preprocessing stage, so that only one multiplier instance is needed. It arbitrates round-robin and issues a one-cycle start with registered operands. It then waits for the multiplier's done, captures the 256-bit product and returns it to the winning requester over a valid/accept handshake. It sits between the ZF preprocessing controllers and a single multiplier instance.

## Interface
- `TIMEOUT_CYCLES`, 64: maximum WAIT cycles before abort; used only with `ZF_ARB_TIMEOUT_EN`.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  2  request per requester; held high until `req_ack`.
- `req_a`  in  2x512  per-requester 4x4 matrix operand (invQ), valid while `req` is high.
- `req_b`  in  2x256  per-requester 4x2 operand (y or n).
- `req_ack`  out  2  one-cycle pulse marking the granted requester; operands are latched on this cycle.
- `mul_start`  out  1  one-cycle start pulse to the multiplier.
- `mul_a`  out  512  registered matrix operand to the multiplier.
- `mul_b`  out  256  registered vector operand to the multiplier.
- `mul_done`  in  1  multiplier done (level).
- `mul_res`  in  256  multiplier product, valid while `mul_done` is high.
- `rsp_valid`  out  2  result valid for each requester; at most one bit set.
- `rsp_data`  out  256  captured product.
- `rsp_err`  out  1  result aborted by timeout; qualified by `rsp_valid`.
- `rsp_accept`  in  2  requester consumes the result.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states:
  - IDLE: if any `req` bit is set, go to ISSUE.
  - ISSUE: go to WAIT.
  - WAIT: on `mul_done`, or on timeout, go to DELIVER.
  - DELIVER: on `rsp_accept[owner]`, go to IDLE.
- Arbitration happens in IDLE only:
  - A single request wins.
  - If both are set, the winner is the side indicated by `rr_ptr`.
  - Grant stores `owner`, sets `rr_ptr` to `~owner`, and registers `mul_a`/`mul_b` from the owner's operands.
- ISSUE: `mul_start`=1 and `req_ack[owner]`=1 for exactly one cycle.
- `mul_a`/`mul_b` hold stable from ISSUE until the next grant.
- WAIT: `mul_done` is ignored in the ISSUE cycle (stale done from the previous job). The first cycle with `mul_done`=1 in WAIT captures `mul_res` into `rsp_data` and clears `rsp_err`.
- DELIVER: `rsp_valid[owner]`=1, held until `rsp_accept[owner]`.
  - `rsp_accept` on the non-owner bit, or outside DELIVER, is ignored.
  - New requests are not granted until the FSM returns to IDLE.
- A requester dropping `req` before its ack is a protocol violation; `req` is sampled only in IDLE.
- Reset (asynchronous, any time, including mid-WAIT): all state cleared, FSM returns to IDLE, and any pending multiplier job is abandoned.
- Reset values:
  - `req_ack`, `mul_start`, `rsp_valid`, `rsp_err`, `busy`: 0.
  - `mul_a`, `mul_b`, `rsp_data`: 0.
  - `rr_ptr`: 0 (requester 0 has first priority).

## Timing
- Cycle 0: `req` seen in IDLE.
- Cycle 1: ISSUE (`mul_start`, `req_ack`).
- Cycle 2 onward: WAIT.
- `mul_done` high at cycle k (k≥2): `rsp_valid` high at k+1.
- `rsp_accept` at cycle m: FSM is in IDLE at m+1. The earliest next `mul_start` is m+2.
- Arbiter overhead per job is 3 cycles plus multiplier latency plus accept delay.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `ZF_ARB_TIMEOUT_EN` defined:
  - A counter runs in WAIT, cleared on entry.
  - When it reaches `TIMEOUT_CYCLES` with no `mul_done`, the FSM goes to DELIVER with `rsp_err`=1 and `rsp_data`=0.
  - If `mul_done` arrives on the same cycle as the timeout, done wins and `rsp_err`=0.
- `ZF_ARB_TIMEOUT_EN` undefined:
  - No counter; WAIT lasts until `mul_done`.
  - `rsp_err` is tied to 0.

## Structure
- Shared package `zf_pkg` holds:
  - `ZF_MAT_W`=512 and `ZF_VEC_W`=256.
  - The arbiter state encoding: IDLE=0, ISSUE=1, WAIT=2, DELIVER=3.
- Sub-module `zf_rr_arbiter2`: combinational 2-way round-robin pick from `req` and `rr_ptr`, returning `grant_valid` and `grant_idx`. The `rr_ptr` register lives in the parent.

## Test plan
- Single request: `req`=01 with `req_b`=pattern P; model multiplier done after 4 cycles.
  - Expect `mul_start` at cycle 1 and `rsp_valid`=01 at cycle 7 with the product of `req_a`×P.
  - `rsp_accept` at cycle 9 gives `busy`=0 at cycle 10.
- Contention: `req`=11 from reset.
  - Expect requester 0 served first, then requester 1, with `req_ack` sequence 01, then 10.
  - Hold `req`=11 continuously with immediate accepts: expect strict alternation for 8 jobs.
- Stale done: `mul_done` held high from the previous job through ISSUE.
  - Expect no capture in ISSUE; capture on the first WAIT cycle.
- Backpressure: withhold `rsp_accept` for 20 cycles while `req[1]` is pending.
  - Expect `rsp_valid` and `rsp_data` stable throughout, and no `mul_start`.
  - A spurious `rsp_accept`=10 while requester 0 owns the result must be ignored.
- Reset mid-WAIT: assert `reset` at cycle 5 of WAIT.
  - Expect all outputs 0 immediately and `rr_ptr`=0.
  - After release, the next `req`=11 grants requester 0.
- Timeout (`ZF_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8): never assert `mul_done`.
  - Expect `rsp_valid` with `rsp_err`=1 and `rsp_data`=0 at WAIT+9.
  - With done and timeout on the same cycle, expect `rsp_err`=0.
